// File: rtl/sb_incr_initiator.sv
// sb_incr_initiator: switchboard-style request/check initiator for a
// byte-incrementing responder. Sends NPKT single-flit packets whose byte i
// is (n + i) mod 256 and checks each response byte equals the sent byte + 1,
// with dest and last passed through unchanged.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// The initiator never retracts tx_valid or changes tx_data while waiting
// for tx_ready, and it only accepts responses while packets are outstanding.
//
// Optional build macro SB_INITIATOR_TIMEOUT_EN adds a watchdog that ends the
// run with timeout=1 when the responder stays silent for TIMEOUT cycles while
// packets are outstanding. Without it timeout is tied low.
module sb_incr_initiator #(
  parameter int          DW      = 256,
  parameter logic [31:0] DEST    = 32'h0,
  parameter int          NPKT    = 16,
  parameter int          MAX_OUT = 4,
  parameter int          TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [DW-1:0] tx_data,
  output logic [31:0]   tx_dest,
  output logic          tx_last,
  output logic          tx_valid,
  input  logic          tx_ready,
  input  logic [DW-1:0] rx_data,
  input  logic [31:0]   rx_dest,
  input  logic          rx_last,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          timeout,
  output logic [15:0]   sent_count,
  output logic [15:0]   recv_count,
  output logic [15:0]   err_count
);

  localparam int NB = DW / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] sent_q, sent_d;
  logic [15:0] recv_q, recv_d;
  logic [15:0] err_q, err_d;
  logic [7:0]  out_q, out_d;
  logic        tx_hs, rx_hs, rx_bad;
  logic [DW-1:0] tx_pattern;

`ifdef SB_INITIATOR_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;
  logic        timeout_q, timeout_d;
`endif

  // Request payload: byte i of packet n is n + i, wrapping in 8 bits.
  always_comb begin
    tx_pattern = '0;
    for (int i = 0; i < NB; i++) begin
      tx_pattern[i*8 +: 8] = sent_q[7:0] + 8'(i);
    end
  end

  // Response check for packet recv_q: every byte must be sent byte + 1.
  always_comb begin
    rx_bad = (rx_dest != DEST) || !rx_last;
    for (int i = 0; i < NB; i++) begin
      if (rx_data[i*8 +: 8] != (recv_q[7:0] + 8'(i) + 8'd1)) begin
        rx_bad = 1'b1;
      end
    end
  end

  assign tx_valid = (state_q == S_RUN) && (sent_q < 16'(NPKT)) && (out_q < 8'(MAX_OUT));
  assign rx_ready = (state_q == S_RUN) && (out_q != 8'd0);
  assign tx_data  = tx_pattern;
  assign tx_dest  = DEST;
  assign tx_last  = 1'b1;
  assign tx_hs    = tx_valid && tx_ready;
  assign rx_hs    = rx_valid && rx_ready;

  // Next-state, counters, outstanding tracking and optional watchdog.
  always_comb begin
    state_d = state_q;
    sent_d  = sent_q;
    recv_d  = recv_q;
    err_d   = err_q;
    out_d   = out_q;
`ifdef SB_INITIATOR_TIMEOUT_EN
    idle_d    = idle_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          sent_d  = '0;
          recv_d  = '0;
          err_d   = '0;
          out_d   = '0;
`ifdef SB_INITIATOR_TIMEOUT_EN
          idle_d    = '0;
          timeout_d = 1'b0;
`endif
        end
      end
      S_RUN: begin
        if (tx_hs) sent_d = sent_q + 16'd1;
        if (rx_hs) begin
          recv_d = recv_q + 16'd1;
          if (rx_bad && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
        end
        case ({tx_hs, rx_hs})
          2'b10:   out_d = out_q + 8'd1;
          2'b01:   out_d = out_q - 8'd1;
          default: out_d = out_q;
        endcase
        if (rx_hs && (recv_q == 16'(NPKT - 1))) state_d = S_DONE;
`ifdef SB_INITIATOR_TIMEOUT_EN
        // Silence is only counted while something is owed to us.
        if (rx_hs || (out_q == 8'd0)) begin
          idle_d = '0;
        end else begin
          idle_d = idle_q + 32'd1;
          if (idle_d == 32'(TIMEOUT)) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
          end
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sent_q  <= '0;
      recv_q  <= '0;
      err_q   <= '0;
      out_q   <= '0;
`ifdef SB_INITIATOR_TIMEOUT_EN
      idle_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sent_q  <= sent_d;
      recv_q  <= recv_d;
      err_q   <= err_d;
      out_q   <= out_d;
`ifdef SB_INITIATOR_TIMEOUT_EN
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
`endif
    end
  end

`ifdef SB_INITIATOR_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  logic unused_timeout_param;
  assign unused_timeout_param = ^32'(TIMEOUT);
  assign timeout = 1'b0;
`endif

  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign pass       = done && (err_q == 16'd0) && !timeout;
  assign sent_count = sent_q;
  assign recv_count = recv_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_sb_incr_initiator.sv
// Testbench for sb_incr_initiator: an incrementer responder model with a
// response budget, a scoreboard of expected request payloads, and one task
// per scenario.
module tb_sb_incr_initiator;

  localparam int          DW      = 256;
  localparam int          NB      = DW / 8;
  localparam logic [31:0] DEST    = 32'h0;
  localparam int          NPKT    = 250;
  localparam int          MAX_OUT = 2;
  localparam int          TIMEOUT = 100;

  logic          clk, rst, start;
  logic [DW-1:0] tx_data, rx_data;
  logic [31:0]   tx_dest, rx_dest;
  logic          tx_last, tx_valid, tx_ready;
  logic          rx_last, rx_valid, rx_ready;
  logic          busy, done, pass, timeout;
  logic [15:0]   sent_count, recv_count, err_count;

  sb_incr_initiator #(
    .DW(DW), .DEST(DEST), .NPKT(NPKT), .MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .tx_data(tx_data), .tx_dest(tx_dest), .tx_last(tx_last),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_dest(rx_dest), .rx_last(rx_last),
    .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .sent_count(sent_count), .recv_count(recv_count), .err_count(err_count)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] rdata_q[$];
  logic [31:0]   rdest_q[$];

  int resp_budget = 0;
  int tx_idx = 0;
  int rx_run = 0;
  int corrupt5_idx = -1;
  int dest_idx = -1;
  int exp_err = 0;

  bit            tx_hs_seen, rx_hs_seen;
  logic          tx_valid_s, done_s, pass_s, busy_s, timeout_s, rx_ready_s;
  logic [DW-1:0] tx_data_s;
  logic [15:0]   sent_s, recv_s, err_s;
  logic [7:0]    out_s;

  function automatic logic [DW-1:0] pattern(input int n, input int add);
    logic [DW-1:0] p;
    p = '0;
    for (int i = 0; i < NB; i++) p[i*8 +: 8] = 8'((n + i + add) % 256);
    return p;
  endfunction

  function automatic logic [DW-1:0] incr(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    for (int i = 0; i < NB; i++) r[i*8 +: 8] = d[i*8 +: 8] + 8'd1;
    return r;
  endfunction

  task automatic drive_rx();
    if (resp_budget > 0 && rdata_q.size() > 0) begin
      rx_valid = 1'b1;
      rx_data  = rdata_q[0];
      rx_dest  = rdest_q[0];
    end else begin
      rx_valid = 1'b0;
      rx_data  = '0;
      rx_dest  = '0;
    end
  endtask

  // One clock: sample at negedge, score handshakes, drive after posedge.
  task automatic cycle();
    logic [DW-1:0] e, r;
    logic [31:0]   d;
    @(negedge clk);
    tx_hs_seen = tx_valid && tx_ready;
    rx_hs_seen = rx_valid && rx_ready;
    tx_valid_s = tx_valid;  tx_data_s = tx_data;  rx_ready_s = rx_ready;
    done_s = done;  pass_s = pass;  busy_s = busy;  timeout_s = timeout;
    sent_s = sent_count;  recv_s = recv_count;  err_s = err_count;
    out_s = dut.out_q;
    if (tx_hs_seen) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL tx_unexpected: got packet %0h, required none", tx_data);
      end else begin
        e = exp_q.pop_front();
        if (tx_data !== e || tx_dest !== DEST || tx_last !== 1'b1) begin
          n_err++;
          $display("FAIL tx_payload[%0d]: got %0h dest %0h last %0b, required %0h dest %0h last 1",
                   tx_idx, tx_data, tx_dest, tx_last, e, DEST);
        end
      end
      r = incr(tx_data);
      d = DEST;
      if (tx_idx == corrupt5_idx) begin r[5*8 +: 8] = r[5*8 +: 8] ^ 8'h5A; exp_err++; end
      if (tx_idx == dest_idx) begin d = 32'h1; exp_err++; end
      rdata_q.push_back(r);
      rdest_q.push_back(d);
      tx_idx++;
    end
    if (rx_hs_seen && rdata_q.size() > 0) begin
      void'(rdata_q.pop_front());
      void'(rdest_q.pop_front());
      resp_budget--;
      rx_run++;
    end
    @(posedge clk);
    #1;
    drive_rx();
  endtask

  task automatic start_run();
    exp_q.delete();
    rdata_q.delete();
    rdest_q.delete();
    for (int n = 0; n < NPKT; n++) exp_q.push_back(pattern(n, 0));
    tx_idx = 0;
    rx_run = 0;
    exp_err = 0;
    drive_rx();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_to_done(input string name);
    int k, fin_k;
    fin_k = -1;
    tx_ready = 1'b1;
    resp_budget = 1000000;
    drive_rx();
    for (k = 0; k < 5000; k++) begin
      cycle();
      if (rx_hs_seen && rx_run == NPKT) fin_k = k;
      if (done_s === 1'b1) break;
    end
    n_cmp++;
    if (!(done_s === 1'b1 && k == fin_k + 1)) begin
      n_err++;
      $display("FAIL %s_done_latency: done=%0b at cycle %0d, final rx at %0d, required done 1 cycle after final rx",
               name, done_s, k, fin_k);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_unsent: got %0d packets unsent, required 0", name, exp_q.size());
    end
    n_cmp++;
    if (sent_s !== 16'(NPKT) || recv_s !== 16'(NPKT) || busy_s !== 1'b0) begin
      n_err++;
      $display("FAIL %s_counts: got sent=%0d recv=%0d busy=%0b, required %0d/%0d/0",
               name, sent_s, recv_s, busy_s, NPKT, NPKT);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cycle();
    n_cmp++;
    if (tx_valid_s !== 1'b0 || rx_ready_s !== 1'b0 || busy_s !== 1'b0 || done_s !== 1'b0 ||
        pass_s !== 1'b0 || timeout_s !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: got txv=%0b rxr=%0b busy=%0b done=%0b pass=%0b to=%0b, required all 0",
               tx_valid_s, rx_ready_s, busy_s, done_s, pass_s, timeout_s);
    end
    n_cmp++;
    if (sent_s !== 16'd0 || recv_s !== 16'd0 || err_s !== 16'd0 || out_s !== 8'd0) begin
      n_err++;
      $display("FAIL reset_counters: got sent=%0d recv=%0d err=%0d out=%0d, required 0",
               sent_s, recv_s, err_s, out_s);
    end
    rst = 1'b0;
    cycle();
    n_cmp++;
    if (tx_valid_s !== 1'b0 || busy_s !== 1'b0) begin
      n_err++;
      $display("FAIL idle_no_start: got txv=%0b busy=%0b, required 0/0", tx_valid_s, busy_s);
    end
  endtask

  task automatic test_nominal();
    tx_ready = 1'b1;
    resp_budget = 1000000;
    start_run();
    run_to_done("nominal");
    n_cmp++;
    if (err_s !== 16'd0 || pass_s !== 1'b1 || timeout_s !== 1'b0) begin
      n_err++;
      $display("FAIL nominal_result: got err=%0d pass=%0b to=%0b, required 0/1/0", err_s, pass_s, timeout_s);
    end
  endtask

  task automatic test_tx_backpressure();
    logic [DW-1:0] d0;
    tx_ready = 1'b0;
    resp_budget = 1000000;
    start_run();
    n_cmp++;
    if (tx_valid_s !== 1'b0) begin
      n_err++;
      $display("FAIL bp_valid_before_start: got %0b, required 0", tx_valid_s);
    end
    cycle();
    n_cmp++;
    if (tx_valid_s !== 1'b1 || done_s !== 1'b0 || sent_s !== 16'd0) begin
      n_err++;
      $display("FAIL bp_valid_after_start: got txv=%0b done=%0b sent=%0d, required 1/0/0",
               tx_valid_s, done_s, sent_s);
    end
    d0 = tx_data_s;
    for (int k = 0; k < 10; k++) begin
      cycle();
      n_cmp++;
      if (tx_valid_s !== 1'b1 || tx_data_s !== d0 || sent_s !== 16'd0) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got txv=%0b sent=%0d data=%0h, required 1/0/%0h",
                 k, tx_valid_s, sent_s, tx_data_s, d0);
      end
    end
    tx_ready = 1'b1;
    cycle();
    cycle();
    n_cmp++;
    if (sent_s !== 16'd1) begin
      n_err++;
      $display("FAIL bp_release: got sent=%0d, required 1", sent_s);
    end
    run_to_done("backpressure");
  endtask

  task automatic test_outstanding();
    int k;
    tx_ready = 1'b1;
    resp_budget = 0;
    start_run();
    repeat (6) cycle();
    n_cmp++;
    if (sent_s !== 16'd2 || tx_valid_s !== 1'b0 || out_s !== 8'd2 || rx_ready_s !== 1'b1) begin
      n_err++;
      $display("FAIL out_limit: got sent=%0d txv=%0b out=%0d rxr=%0b, required 2/0/2/1",
               sent_s, tx_valid_s, out_s, rx_ready_s);
    end
    resp_budget = 1;
    drive_rx();
    for (k = 0; k < 10; k++) begin
      cycle();
      if (rx_hs_seen) break;
    end
    n_cmp++;
    if (!rx_hs_seen || tx_valid_s !== 1'b0) begin
      n_err++;
      $display("FAIL out_one_rx: got rx_hs=%0b txv=%0b, required 1/0", rx_hs_seen, tx_valid_s);
    end
    resp_budget = 1;
    drive_rx();
    cycle();
    n_cmp++;
    if (tx_valid_s !== 1'b1 || !(tx_hs_seen && rx_hs_seen)) begin
      n_err++;
      $display("FAIL out_reopen: got txv=%0b tx_hs=%0b rx_hs=%0b, required 1/1/1",
               tx_valid_s, tx_hs_seen, rx_hs_seen);
    end
    cycle();
    n_cmp++;
    if (out_s !== 8'd1 || sent_s !== 16'd3 || recv_s !== 16'd2) begin
      n_err++;
      $display("FAIL out_simultaneous: got out=%0d sent=%0d recv=%0d, required 1/3/2",
               out_s, sent_s, recv_s);
    end
    cycle();
    n_cmp++;
    if (out_s !== 8'd2 || tx_valid_s !== 1'b0) begin
      n_err++;
      $display("FAIL out_refill: got out=%0d txv=%0b, required 2/0", out_s, tx_valid_s);
    end
    run_to_done("outstanding");
    n_cmp++;
    if (pass_s !== 1'b1) begin
      n_err++;
      $display("FAIL out_pass: got %0b, required 1", pass_s);
    end
  endtask

  task automatic test_corruption();
    corrupt5_idx = 2;
    dest_idx = 3;
    tx_ready = 1'b1;
    resp_budget = 1000000;
    start_run();
    run_to_done("corrupt");
    n_cmp++;
    if (err_s !== 16'(exp_err) || pass_s !== 1'b0 || done_s !== 1'b1) begin
      n_err++;
      $display("FAIL corrupt_result: got err=%0d pass=%0b done=%0b, required %0d/0/1",
               err_s, pass_s, done_s, exp_err);
    end
    corrupt5_idx = -1;
    dest_idx = -1;
  endtask

  task automatic test_reset_mid_run();
    int k;
    tx_ready = 1'b1;
    resp_budget = 1000000;
    start_run();
    for (k = 0; k < 20; k++) begin
      cycle();
      if (sent_s == 16'd2) break;
    end
    rst = 1'b1;
    cycle();
    cycle();
    n_cmp++;
    if (tx_valid_s !== 1'b0 || rx_ready_s !== 1'b0 || sent_s !== 16'd0 || recv_s !== 16'd0 ||
        err_s !== 16'd0 || out_s !== 8'd0 || busy_s !== 1'b0 || done_s !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_state: got txv=%0b rxr=%0b sent=%0d recv=%0d err=%0d out=%0d busy=%0b done=%0b, required idle zeros",
               tx_valid_s, rx_ready_s, sent_s, recv_s, err_s, out_s, busy_s, done_s);
    end
    rst = 1'b0;
    rdata_q.delete();
    rdest_q.delete();
    drive_rx();
    start_run();
    for (k = 0; k < 10; k++) begin
      cycle();
      if (tx_hs_seen) break;
    end
    n_cmp++;
    if (!tx_hs_seen || tx_data_s[7:0] !== 8'd0 || tx_data_s[15:8] !== 8'd1) begin
      n_err++;
      $display("FAIL midreset_first: got hs=%0b byte0=%0d byte1=%0d, required 1/0/1",
               tx_hs_seen, tx_data_s[7:0], tx_data_s[15:8]);
    end
    run_to_done("midreset");
    n_cmp++;
    if (pass_s !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_pass: got %0b, required 1", pass_s);
    end
  endtask

`ifdef SB_INITIATOR_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    tx_ready = 1'b1;
    resp_budget = 0;
    start_run();
    for (k = 0; k < 10; k++) begin
      cycle();
      if (tx_hs_seen) break;
    end
    repeat (TIMEOUT) cycle();
    n_cmp++;
    if (timeout_s !== 1'b0 || done_s !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_early: got to=%0b done=%0b, required 0/0", timeout_s, done_s);
    end
    cycle();
    n_cmp++;
    if (timeout_s !== 1'b1 || done_s !== 1'b1 || pass_s !== 1'b0 || sent_s !== 16'd2) begin
      n_err++;
      $display("FAIL timeout_fire: got to=%0b done=%0b pass=%0b sent=%0d, required 1/1/0/2",
               timeout_s, done_s, pass_s, sent_s);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    start = 1'b0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data = '0;
    rx_dest = '0;
    rx_last = 1'b1;
    test_reset();
    test_nominal();
    test_tx_backpressure();
    test_outstanding();
    test_corruption();
    test_reset_mid_run();
`ifdef SB_INITIATOR_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
